// File: rtl/icosine_transformer.sv
// 8x8 inverse DCT: collects Q16.16 coefficients, runs separable row/column passes with one MAC per cycle,
// then streams 64 pixels in raster order. Input is stalled while a block is in flight; output holds under backpressure.
module icosine_transformer #(
    parameter int Q_BIT     = 32,
    parameter int PIXEL_BIT = 8,
    parameter int BLOCK_BIT = 3
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [Q_BIT-1:0]     dq_veri_i,
    input  logic [BLOCK_BIT-1:0] dq_row_i,
    input  logic [BLOCK_BIT-1:0] dq_col_i,
    input  logic                 dq_gecerli_i,
    input  logic                 dq_blok_son_i,
    output logic                 dq_hazir_o,
    output logic [PIXEL_BIT-1:0] gd_veri_o,
    output logic [BLOCK_BIT-1:0] gd_row_o,
    output logic [BLOCK_BIT-1:0] gd_col_o,
    output logic                 gd_gecerli_o,
    output logic                 gd_blok_son_o,
    input  logic                 gd_hazir_i
);
    localparam int IDX_W  = 2 * BLOCK_BIT;
    localparam int N      = 1 << IDX_W;
    localparam int T_W    = Q_BIT + 8;
    localparam int K_W    = 24;
    localparam int K_FRAC = 20;
    localparam int T_FRAC = 16;
    localparam int ACC_W  = 64;
    localparam logic signed [ACC_W-1:0] RND_ROW = ACC_W'(1) << (K_FRAC - 1);
    localparam logic signed [ACC_W-1:0] RND_COL = ACC_W'(1) << (K_FRAC + T_FRAC - 1);
    localparam logic signed [ACC_W-1:0] PIX_OFS = ACC_W'(1) << (PIXEL_BIT - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX = (ACC_W'(1) << PIXEL_BIT) - ACC_W'(1);

    typedef enum logic [1:0] {COLLECT, ROW_PASS, COL_PASS, EMIT} state_t;

    state_t                state;
    logic [Q_BIT-1:0]      cbuf [N];
    logic [T_W-1:0]        tbuf [N];
    logic [PIXEL_BIT-1:0]  pbuf [N];
    logic [IDX_W-1:0]      oidx;
    logic [IDX_W-1:0]      eidx;
    logic [IDX_W-1:0]      enext;
    logic [BLOCK_BIT-1:0]  k;
    logic signed [ACC_W-1:0] acc;

    logic [Q_BIT-1:0]        cw;
    logic [T_W-1:0]          mul_a;
    logic [K_W-1:0]          mul_b;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] pix_full;
    logic [T_W-1:0]          row_val;
    logic [PIXEL_BIT-1:0]    pix;

    // C(f)/2 * cos((2n+1) f pi/16) scaled by 2^20, folded from one quarter-wave of cosine
    function automatic logic signed [K_W-1:0] cos_k(input logic [BLOCK_BIT-1:0] n,
                                                    input logic [BLOCK_BIT-1:0] f);
        int m;
        logic neg;
        logic signed [K_W-1:0] mag;
        m = ((2 * int'(n) + 1) * int'(f)) % 32;
        if (m > 16) m = 32 - m;
        neg = (m > 8);
        if (neg) m = 16 - m;
        case (m)
            0:       mag = 24'sd524288;
            1:       mag = 24'sd514214;
            2:       mag = 24'sd484379;
            3:       mag = 24'sd435930;
            4:       mag = 24'sd370728;
            5:       mag = 24'sd291279;
            6:       mag = 24'sd200636;
            7:       mag = 24'sd102284;
            default: mag = 24'sd0;
        endcase
        if (f == '0) cos_k = 24'sd370728;
        else         cos_k = neg ? -mag : mag;
    endfunction

    assign dq_hazir_o = rstn_i && (state == COLLECT);
    assign enext      = eidx + 1'b1;

    always_comb begin
        cw    = '0;
        mul_a = '0;
        mul_b = '0;
        case (state)
            ROW_PASS: begin
                cw    = cbuf[{oidx[IDX_W-1:BLOCK_BIT], k}];
                mul_a = {{(T_W-Q_BIT){cw[Q_BIT-1]}}, cw};
                mul_b = cos_k(oidx[BLOCK_BIT-1:0], k);
            end
            COL_PASS: begin
                mul_a = tbuf[{k, oidx[BLOCK_BIT-1:0]}];
                mul_b = cos_k(oidx[IDX_W-1:BLOCK_BIT], k);
            end
            default: ;
        endcase
        prod     = {{(ACC_W-T_W){mul_a[T_W-1]}}, mul_a} * {{(ACC_W-K_W){mul_b[K_W-1]}}, mul_b};
        acc_sum  = acc + prod;
        row_val  = T_W'((acc_sum + RND_ROW) >>> K_FRAC);
        pix_full = ((acc_sum + RND_COL) >>> (K_FRAC + T_FRAC)) + PIX_OFS;
        if (pix_full[ACC_W-1])      pix = '0;
        else if (pix_full > PIX_MAX) pix = '1;
        else                         pix = PIXEL_BIT'(pix_full);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state         <= COLLECT;
            oidx          <= '0;
            eidx          <= '0;
            k             <= '0;
            acc           <= '0;
            gd_gecerli_o  <= 1'b0;
            gd_veri_o     <= '0;
            gd_row_o      <= '0;
            gd_col_o      <= '0;
            gd_blok_son_o <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cbuf[i] <= '0;
                tbuf[i] <= '0;
                pbuf[i] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (dq_gecerli_i) begin
                        cbuf[{dq_row_i, dq_col_i}] <= dq_veri_i;
                        if (dq_blok_son_i) begin
                            state <= ROW_PASS;
                            oidx  <= '0;
                            k     <= '0;
                            acc   <= '0;
                        end
                    end
                end
                ROW_PASS: begin
                    k <= k + 1'b1;
                    if (k == {BLOCK_BIT{1'b1}}) begin
                        acc        <= '0;
                        tbuf[oidx] <= row_val;
                        oidx       <= oidx + 1'b1;
                        if (oidx == {IDX_W{1'b1}}) state <= COL_PASS;
                    end else begin
                        acc <= acc_sum;
                    end
                end
                COL_PASS: begin
                    k <= k + 1'b1;
                    if (k == {BLOCK_BIT{1'b1}}) begin
                        acc        <= '0;
                        pbuf[oidx] <= pix;
                        oidx       <= oidx + 1'b1;
                        if (oidx == {IDX_W{1'b1}}) begin
                            state         <= EMIT;
                            eidx          <= '0;
                            gd_gecerli_o  <= 1'b1;
                            gd_veri_o     <= pbuf[0];
                            gd_row_o      <= '0;
                            gd_col_o      <= '0;
                            gd_blok_son_o <= 1'b0;
                        end
                    end else begin
                        acc <= acc_sum;
                    end
                end
                EMIT: begin
                    if (gd_hazir_i) begin
                        if (eidx == {IDX_W{1'b1}}) begin
                            state         <= COLLECT;
                            gd_gecerli_o  <= 1'b0;
                            gd_blok_son_o <= 1'b0;
                            for (int i = 0; i < N; i++) cbuf[i] <= '0;
                        end else begin
                            eidx          <= enext;
                            gd_veri_o     <= pbuf[enext];
                            gd_row_o      <= enext[IDX_W-1:BLOCK_BIT];
                            gd_col_o      <= enext[BLOCK_BIT-1:0];
                            gd_blok_son_o <= (enext == {IDX_W{1'b1}});
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_icosine_transformer.sv
// Randomised and directed blocks against a floating-point 2-D IDCT model, scoreboard-checked.
module tb_icosine_transformer;
    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [31:0] dq_veri_i;
    logic [2:0]  dq_row_i, dq_col_i;
    logic        dq_gecerli_i, dq_blok_son_i, dq_hazir_o;
    logic [7:0]  gd_veri_o;
    logic [2:0]  gd_row_o, gd_col_o;
    logic        gd_gecerli_o, gd_blok_son_o, gd_hazir_i;

    icosine_transformer #(.Q_BIT(32), .PIXEL_BIT(8), .BLOCK_BIT(3)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .dq_veri_i(dq_veri_i), .dq_row_i(dq_row_i), .dq_col_i(dq_col_i),
        .dq_gecerli_i(dq_gecerli_i), .dq_blok_son_i(dq_blok_son_i), .dq_hazir_o(dq_hazir_o),
        .gd_veri_o(gd_veri_o), .gd_row_o(gd_row_o), .gd_col_o(gd_col_o),
        .gd_gecerli_o(gd_gecerli_o), .gd_blok_son_o(gd_blok_son_o), .gd_hazir_i(gd_hazir_i)
    );

    typedef struct {int val; int row; int col; bit last;} exp_t;
    exp_t exp_q[$];
    real  coef [8][8];
    int   n_checks = 0, n_fail = 0;
    int   cyc_cnt = 0, xfer_first = 0, xfer_last = 0, xfer_cnt = 0;
    bit   hz_rand = 1'b0;
    localparam real PI = 3.14159265358979323846;

    initial forever #5 clk_i = ~clk_i;
    initial forever begin @(posedge clk_i); cyc_cnt++; end

    initial begin
        gd_hazir_i = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            gd_hazir_i = hz_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic int model_pixel(input int y, input int x);
        real s = 0.0;
        real cu, cv;
        int  p;
        for (int u = 0; u < 8; u++) begin
            for (int v = 0; v < 8; v++) begin
                cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                cv = (v == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                s += cu * cv * coef[v][u] * $cos((2 * x + 1) * u * PI / 16.0)
                                          * $cos((2 * y + 1) * v * PI / 16.0);
            end
        end
        s = s / 4.0;
        p = int'($floor(s + 0.5)) + 128;
        if (p < 0) p = 0;
        if (p > 255) p = 255;
        return p;
    endfunction

    // Monitor: scoreboard pop on each transfer, plus stability under stall
    initial begin
        exp_t e;
        bit   stall_prev = 1'b0;
        logic [14:0] saved = '0;
        int   diff;
        forever begin
            @(negedge clk_i);
            if (rstn_i && stall_prev) begin
                n_checks++;
                if ({gd_veri_o, gd_row_o, gd_col_o, gd_blok_son_o} != saved) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h, expected %h",
                             {gd_veri_o, gd_row_o, gd_col_o, gd_blok_son_o}, saved);
                end
            end
            if (gd_gecerli_o && gd_hazir_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pixel: got y=%0d x=%0d v=%0d, expected none",
                             gd_row_o, gd_col_o, gd_veri_o);
                end else begin
                    e = exp_q.pop_front();
                    diff = int'(gd_veri_o) - e.val;
                    if (diff > 1 || diff < -1 || int'(gd_row_o) != e.row ||
                        int'(gd_col_o) != e.col || gd_blok_son_o != e.last) begin
                        n_fail++;
                        $display("FAIL pixel: got y=%0d x=%0d v=%0d last=%0d, expected y=%0d x=%0d v=%0d last=%0d",
                                 gd_row_o, gd_col_o, gd_veri_o, gd_blok_son_o,
                                 e.row, e.col, e.val, e.last);
                    end
                end
                if (xfer_cnt == 0) xfer_first = cyc_cnt;
                xfer_last = cyc_cnt;
                xfer_cnt++;
            end
            stall_prev = gd_gecerli_o && !gd_hazir_i;
            saved = {gd_veri_o, gd_row_o, gd_col_o, gd_blok_son_o};
        end
    end

    task automatic clear_model();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) coef[r][c] = 0.0;
    endtask

    task automatic send(input int row, input int col, input int q, input bit last);
        int t = 0;
        @(negedge clk_i);
        dq_veri_i = q; dq_row_i = 3'(row); dq_col_i = 3'(col);
        dq_blok_son_i = last; dq_gecerli_i = 1'b1;
        while (!dq_hazir_o && t < 3000) begin @(negedge clk_i); t++; end
        if (!dq_hazir_o) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: got ready=0, expected 1");
        end
        @(posedge clk_i); #1;
        dq_gecerli_i = 1'b0; dq_blok_son_i = 1'b0;
        coef[row][col] = $itor(q) / 65536.0;
    endtask

    task automatic run_block(input string name);
        int cyc = 0, first = -1, bad = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                exp_q.push_back('{model_pixel(y, x), y, x, (y == 7 && x == 7)});
        xfer_cnt = 0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            @(negedge clk_i); #1;
            cyc++;
            if (first < 0 && gd_gecerli_o) first = cyc;
            if (exp_q.size() > 0 && dq_hazir_o) bad++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        chk({name, "_latency_ok"}, int'(first > 0 && first <= 1200), 1);
        chk({name, "_busy_not_ready"}, bad, 0);
        if (!hz_rand) chk({name, "_consecutive"}, xfer_last - xfer_first, 63);
        @(posedge clk_i); #1;
        chk({name, "_ready_after"}, int'(dq_hazir_o), 1);
    endtask

    task automatic send_ramp();
        for (int i = 0; i < 64; i++) send(i / 8, i % 8, (i * 64) * 65536, i == 63);
    endtask

    initial begin
        rstn_i = 1'b0; dq_veri_i = '0; dq_row_i = '0; dq_col_i = '0;
        dq_gecerli_i = 1'b0; dq_blok_son_i = 1'b0;
        clear_model();
        repeat (3) @(negedge clk_i);
        chk("rst_hazir", int'(dq_hazir_o), 0);
        chk("rst_gecerli", int'(gd_gecerli_o), 0);
        chk("rst_veri", int'(gd_veri_o), 0);
        chk("rst_row", int'(gd_row_o), 0);
        chk("rst_col", int'(gd_col_o), 0);
        chk("rst_blok_son", int'(gd_blok_son_o), 0);
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_release_ready", int'(dq_hazir_o), 1);

        clear_model(); send(7, 7, 0, 1'b1); run_block("zero");
        clear_model(); send(0, 0, 64 * 65536, 1'b1); run_block("dc64");
        clear_model(); send(0, 0, 2000 * 65536, 1'b1); run_block("dc_pos_sat");
        clear_model(); send(0, 0, -2000 * 65536, 1'b1); run_block("dc_neg_sat");
        clear_model(); send_ramp(); run_block("ramp");
        hz_rand = 1'b1;
        clear_model(); send_ramp(); run_block("ramp_stall");

        for (int b = 0; b < 3; b++) begin
            int n;
            clear_model();
            n = $urandom_range(1, 80);
            for (int j = 0; j < n; j++)
                send($urandom_range(0, 7), $urandom_range(0, 7),
                     (int'($urandom_range(0, 2047)) - 1024) * 65536 + int'($urandom_range(0, 65535)),
                     j == n - 1);
            run_block($sformatf("rand%0d", b));
        end

        hz_rand = 1'b0;
        clear_model(); send_ramp();
        repeat (700) @(negedge clk_i);
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        chk("midrst_ready", int'(dq_hazir_o), 1);
        chk("midrst_gecerli", int'(gd_gecerli_o), 0);
        clear_model(); send(0, 0, 64 * 65536, 1'b1); run_block("post_rst_dc64");
        repeat (1300) @(negedge clk_i);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/icosine_transformer.md
ICOSINE_TRANSFORMER -- requirements
Module: icosine_transformer

Interface
REQ-001 SHALL have parameter Q_BIT, default 32: dequantized coefficient width, signed fixed point Q16.16 with integer field [31:16] (Q_INT) and fraction [15:0].
REQ-002 SHALL have parameter PIXEL_BIT, default 8: output pixel width, unsigned.
REQ-003 SHALL have parameter BLOCK_BIT, default 3: row/column index width within the 8x8 block.
REQ-004 SHALL use one clock and a synchronous, active-low reset: clk_i, rising edge; rstn_i, sampled only on clk_i.
REQ-005 clk_i  input  1  clock.
REQ-006 rstn_i  input  1  synchronous active-low reset.
REQ-007 dq_veri_i  input  Q_BIT  coefficient F(row,col), signed Q16.16.
REQ-008 dq_row_i  input  BLOCK_BIT  vertical frequency index v.
REQ-009 dq_col_i  input  BLOCK_BIT  horizontal frequency index u.
REQ-010 dq_gecerli_i  input  1  input valid.
REQ-011 dq_blok_son_i  input  1  marks last coefficient of a block.
REQ-012 dq_hazir_o  output  1  input ready.
REQ-013 gd_veri_o  output  PIXEL_BIT  reconstructed pixel.
REQ-014 gd_row_o  output  BLOCK_BIT  pixel row y.
REQ-015 gd_col_o  output  BLOCK_BIT  pixel column x.
REQ-016 gd_gecerli_o  output  1  output valid.
REQ-017 gd_blok_son_o  output  1  asserted with the 64th (y=7,x=7) pixel.
REQ-018 gd_hazir_i  input  1  downstream ready.

Function
REQ-019 Input transfer SHALL occur on a clock edge where dq_gecerli_i && dq_hazir_o; output transfer where gd_gecerli_o && gd_hazir_i.
REQ-020 SHALL implement states COLLECT -> ROW_PASS -> COL_PASS -> EMIT -> COLLECT.
REQ-021 In COLLECT dq_hazir_o SHALL be 1; each transfer writes dq_veri_i into a 64-entry coefficient buffer at (dq_row_i,dq_col_i); a repeated address overwrites.
REQ-022 A transfer with dq_blok_son_i=1 SHALL leave COLLECT for ROW_PASS on the next cycle; dq_hazir_o SHALL be 0 in all other states.
REQ-023 Coefficient buffer entries not written in a block SHALL read as zero (buffer cleared on reset and on leaving EMIT).
REQ-024 SHALL compute f(y,x) = 1/4 * sum_u sum_v C(u)C(v) F(v,u) cos((2x+1)u*pi/16) cos((2y+1)v*pi/16), C(0)=1/sqrt2, else 1, separably: ROW_PASS 1-D IDCT per row into an intermediate buffer, COL_PASS per column.
REQ-025 Cosine coefficients SHALL be a constant 8x8 table, signed, >=14 fractional bits; intermediates SHALL keep >=4 guard fractional bits and be wide enough never to overflow for |F| < 2^15.
REQ-026 Pixel SHALL be round-half-up(f(y,x)) + 128, saturated to [0, 255].
REQ-027 Each pixel SHALL be within +/-1 of a double-precision evaluation of REQ-026.
REQ-028 EMIT SHALL output 64 pixels in raster order (y outer, x inner, 0..7), gd_row_o=y, gd_col_o=x, gd_blok_son_o=1 only at y=7,x=7.
REQ-029 While gd_gecerli_o=1 and gd_hazir_i=0, gd_veri_o, gd_row_o, gd_col_o, gd_blok_son_o SHALL hold stable; no pixel dropped or duplicated.
REQ-030 First gd_gecerli_o SHALL assert no more than 1200 cycles after the blok_son transfer; with gd_hazir_i=1 continuously, 64 pixels SHALL emit on 64 consecutive cycles.
REQ-031 After the final output transfer, dq_hazir_o SHALL be 1 on the next cycle.
REQ-032 gd_gecerli_o SHALL be 0 outside EMIT; input with dq_gecerli_i=0 SHALL have no effect.

Reset
REQ-033 With rstn_i=0 at a clock edge: state COLLECT, buffers cleared, dq_hazir_o=0 while rstn_i=0, gd_gecerli_o=0, gd_veri_o=0, gd_row_o=0, gd_col_o=0, gd_blok_son_o=0.
REQ-034 Reset mid-block (any state) SHALL abandon the block; no pixel of it SHALL appear afterwards; dq_hazir_o=1 on the first cycle after rstn_i returns to 1.

Verification
REQ-035 All-zero block (only F(7,7)=0 sent with blok_son) -> 64 pixels, all 128, raster order, blok_son on 64th.
REQ-036 DC only, F(0,0) integer field=64, rest unsent -> all 64 pixels = 136.
REQ-037 DC F(0,0)=+2000 -> all 255; F(0,0)=-2000 -> all 0 (saturation).
REQ-038 64 coefficients in raster order, integer field = i*64 (i=0..63), blok_son at i=63, gd_hazir_i=1 -> every pixel within +/-1 of double-precision model; dq_hazir_o=0 from after i=63 until the last pixel transfers.
REQ-039 Same block with gd_hazir_i pseudo-random 50% -> identical pixel sequence, outputs stable while stalled.
REQ-040 Assert rstn_i=0 for 1 cycle during COL_PASS, then send DC-only block F(0,0)=64 -> only 64 pixels of 136 emitted.
